// File: rtl/vec_alu_sequencer.sv
// Issue/writeback sequencer for the 64-bit vector ALU.
// Streams one element per cycle through a read -> ALU -> writeback pipeline.
module vec_alu_sequencer #(
  parameter int unsigned VLEN_MAX = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_width,
  input  logic [5:0]        cmd_len,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_src_c,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rf_ren,
  output logic [ADDR_W-1:0] rf_raddr_a,
  output logic [ADDR_W-1:0] rf_raddr_b,
  output logic [ADDR_W-1:0] rf_raddr_c,
  input  logic [63:0]       rf_rdata_a,
  input  logic [63:0]       rf_rdata_b,
  input  logic [63:0]       rf_rdata_c,
  output logic [63:0]       alu_a,
  output logic [63:0]       alu_b,
  output logic [63:0]       alu_c,
  output logic [2:0]        alu_operation,
  output logic [2:0]        alu_num_bits,
  output logic              alu_enable,
  input  logic [63:0]       alu_out,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [63:0]       rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [5:0] LenMax = 6'(VLEN_MAX);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d, width_q, width_d;
  logic [5:0]        len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, src_c_q, src_c_d, dst_q, dst_d;
  logic [ADDR_W-1:0] raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d, raddr_c_q, raddr_c_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              ren_q, ren_d, alu_en_q, alu_en_d, we_q, we_d, done_q, done_d, err_q, err_d;
  logic              accept, illegal;

  assign accept  = cmd_valid && (state_q == StIdle);
  assign illegal = (cmd_op > 3'd3) || (cmd_width > 3'd3) || (cmd_len > LenMax);

  // Next-state: FSM, read address generation and pipeline valid shifting.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    width_d   = width_q;
    len_d     = len_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    src_c_d   = src_c_q;
    dst_d     = dst_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    ren_d     = 1'b0;
    raddr_a_d = '0;
    raddr_b_d = '0;
    raddr_c_d = '0;
    alu_en_d  = ren_q;     // read data arrives one cycle after rf_ren
    we_d      = alu_en_q;  // ALU result arrives one cycle after alu_enable
    waddr_d   = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (alu_en_q) begin
      waddr_d  = dst_q + ADDR_W'(wr_cnt_q);
      wr_cnt_d = wr_cnt_q + 6'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else if (cmd_len == 6'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = StRun;
            op_d      = cmd_op;
            width_d   = cmd_width;
            len_d     = cmd_len;
            src_a_d   = cmd_src_a;
            src_b_d   = cmd_src_b;
            src_c_d   = cmd_src_c;
            dst_d     = cmd_dst;
            rd_cnt_d  = 6'd1;
            wr_cnt_d  = 6'd0;
            ren_d     = 1'b1;
            raddr_a_d = cmd_src_a;
            raddr_b_d = cmd_src_b;
            raddr_c_d = cmd_src_c;
          end
        end
      end
      StRun: begin
        if (rd_cnt_q == len_q) begin
          state_d = StDrain;
        end else begin
          ren_d     = 1'b1;
          raddr_a_d = src_a_q + ADDR_W'(rd_cnt_q);
          raddr_b_d = src_b_q + ADDR_W'(rd_cnt_q);
          raddr_c_d = src_c_q + ADDR_W'(rd_cnt_q);
          rd_cnt_d  = rd_cnt_q + 6'd1;
        end
      end
      StDrain: begin
        // Last write is in flight once nothing is left in the ALU stage.
        if (we_q && !alu_en_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
          op_d    = 3'd0;
          width_d = 3'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and pipeline registers; async reset abandons any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      op_q      <= '0;
      width_q   <= '0;
      len_q     <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      src_c_q   <= '0;
      dst_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ren_q     <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      raddr_c_q <= '0;
      alu_en_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      width_q   <= width_d;
      len_q     <= len_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      src_c_q   <= src_c_d;
      dst_q     <= dst_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      ren_q     <= ren_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      raddr_c_q <= raddr_c_d;
      alu_en_q  <= alu_en_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign rf_ren        = ren_q;
  assign rf_raddr_a    = raddr_a_q;
  assign rf_raddr_b    = raddr_b_q;
  assign rf_raddr_c    = raddr_c_q;
  assign alu_enable    = alu_en_q;
  assign alu_operation = op_q;
  assign alu_num_bits  = width_q;
  assign alu_a         = alu_en_q ? rf_rdata_a : '0;
  assign alu_b         = alu_en_q ? rf_rdata_b : '0;
  assign alu_c         = alu_en_q ? rf_rdata_c : '0;
  assign rf_we         = we_q;
  assign rf_waddr      = waddr_q;
  assign rf_wdata      = we_q ? alu_out : '0;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Scoreboard bench for vec_alu_sequencer with behavioural RF and ALU models.
module tb_vec_alu_sequencer;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op, cmd_width;
  logic [5:0]    cmd_len;
  logic [AW-1:0] cmd_src_a, cmd_src_b, cmd_src_c, cmd_dst;
  logic          rf_ren;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_raddr_c;
  logic [63:0]   rf_rdata_a = '0, rf_rdata_b = '0, rf_rdata_c = '0;
  logic [63:0]   alu_a, alu_b, alu_c;
  logic [2:0]    alu_operation, alu_num_bits;
  logic          alu_enable;
  logic [63:0]   alu_out = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [63:0]   rf_wdata;
  logic          busy, done, err;

  vec_alu_sequencer #(.VLEN_MAX(32), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_width(cmd_width),
    .cmd_len(cmd_len), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_src_c(cmd_src_c),
    .cmd_dst(cmd_dst), .rf_ren(rf_ren), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_raddr_c(rf_raddr_c), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_rdata_c(rf_rdata_c), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_operation(alu_operation), .alu_num_bits(alu_num_bits), .alu_enable(alu_enable),
    .alu_out(alu_out), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [63:0] mem [32];

  typedef struct {int cyc; logic [AW-1:0] a, b, c;} rd_ev_t;
  typedef struct {int cyc; logic [63:0] a, b, c; logic [2:0] op, wd;} alu_ev_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [63:0] data;} wr_ev_t;
  rd_ev_t  q_rd[$];
  alu_ev_t q_alu[$];
  wr_ev_t  q_wr[$];
  int      q_done[$];
  int      q_err[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [63:0] alu_fn(input logic [2:0] op, input logic [63:0] a, b, c);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a * b;
      3'd2:    return a - b;
      default: return a * b + c;
    endcase
  endfunction

  // Register file: synchronous read, data valid the cycle after rf_ren.
  always @(posedge clk) begin
    if (rf_ren) begin
      rf_rdata_a <= mem[rf_raddr_a];
      rf_rdata_b <= mem[rf_raddr_b];
      rf_rdata_c <= mem[rf_raddr_c];
    end
  end

  // ALU: registered result, full 64-bit arithmetic.
  always @(posedge clk) begin
    if (alu_enable) alu_out <= alu_fn(alu_operation, alu_a, alu_b, alu_c);
  end

  // Compare DUT outputs against the scoreboard each cycle.
  always @(negedge clk) begin : monitor
    bit e;
    rd_ev_t r;
    alu_ev_t x;
    wr_ev_t w;
    if (mon_en && rstn) begin
      e = (q_rd.size() > 0) && (q_rd[0].cyc == cyc);
      check_eq("rf_ren", rf_ren, e);
      if (e) begin
        r = q_rd.pop_front();
        check_eq("raddr_a", rf_raddr_a, r.a);
        check_eq("raddr_b", rf_raddr_b, r.b);
        check_eq("raddr_c", rf_raddr_c, r.c);
      end
      e = (q_alu.size() > 0) && (q_alu[0].cyc == cyc);
      check_eq("alu_enable", alu_enable, e);
      if (e) begin
        x = q_alu.pop_front();
        check_eq("alu_a", alu_a, x.a);
        check_eq("alu_b", alu_b, x.b);
        check_eq("alu_c", alu_c, x.c);
        check_eq("alu_operation", alu_operation, x.op);
        check_eq("alu_num_bits", alu_num_bits, x.wd);
      end else begin
        check_eq("alu_a_idle", alu_a, 0);
      end
      e = (q_wr.size() > 0) && (q_wr[0].cyc == cyc);
      check_eq("rf_we", rf_we, e);
      if (e) begin
        w = q_wr.pop_front();
        check_eq("rf_waddr", rf_waddr, w.addr);
        check_eq("rf_wdata", rf_wdata, w.data);
      end
      e = (q_done.size() > 0) && (q_done[0] == cyc);
      check_eq("done", done, e);
      if (e) void'(q_done.pop_front());
      e = (q_err.size() > 0) && (q_err[0] == cyc);
      check_eq("err", err, e);
      if (e) void'(q_err.pop_front());
      if (!busy) check_eq("idle_op", {alu_operation, alu_num_bits}, 0);
    end
  end

  // Drive one command, push its expected events, return the index of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [2:0] wd, input logic [5:0] len,
                       input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                       input logic [AW-1:0] sc, input logic [AW-1:0] d, output int acc);
    int k;
    logic [AW-1:0] ia, ib, ic, id;
    cmd_op = op; cmd_width = wd; cmd_len = len;
    cmd_src_a = sa; cmd_src_b = sb; cmd_src_c = sc; cmd_dst = d;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      check_eq("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (op > 3 || wd > 3 || len > 32) begin
      q_err.push_back(acc);
    end else if (len == 0) begin
      q_done.push_back(acc);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        ia = sa + i[AW-1:0]; ib = sb + i[AW-1:0]; ic = sc + i[AW-1:0]; id = d + i[AW-1:0];
        q_rd.push_back('{cyc: acc + i, a: ia, b: ib, c: ic});
        q_alu.push_back('{cyc: acc + 1 + i, a: mem[ia], b: mem[ib], c: mem[ic], op: op, wd: wd});
        q_wr.push_back('{cyc: acc + 2 + i, addr: id,
                         data: alu_fn(op, mem[ia], mem[ib], mem[ic])});
      end
      q_done.push_back(acc + int'(len) + 2);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q_rd.size() + q_alu.size() + q_wr.size() + q_done.size() + q_err.size()) != 0
           && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", q_rd.size() + q_alu.size() + q_wr.size() + q_done.size()
             + q_err.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1, a2;
    cmd_valid = 1'b0; cmd_op = '0; cmd_width = '0; cmd_len = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_src_c = '0; cmd_dst = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ren", rf_ren, 0);
    check_eq("rst_alu_en", alu_enable, 0);
    check_eq("rst_we", rf_we, 0);
    rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", cmd_ready, 1);

    // 8-bit add, len 4.
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 255;
    for (int i = 4; i < 8; i++) mem[i] = 1;
    issue(3'd0, 3'd0, 6'd4, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    wait_idle();

    // 16-bit mac with source wrap: 2*3+5 = 11 three times.
    mem[31] = 2; mem[0] = 2; mem[1] = 2;
    for (int i = 12; i < 15; i++) mem[i] = 3;
    for (int i = 20; i < 23; i++) mem[i] = 5;
    issue(3'd3, 3'd1, 6'd3, 5'd31, 5'd12, 5'd20, 5'd24, a1);
    wait_idle();

    // Illegal op and width, then len 0 and len 33.
    issue(3'd5, 3'd0, 6'd4, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    check_eq("illegal_ready", cmd_ready, 1);
    check_eq("illegal_busy", busy, 0);
    issue(3'd0, 3'd4, 6'd2, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    issue(3'd0, 3'd0, 6'd0, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    check_eq("zero_len_busy", busy, 0);
    issue(3'd0, 3'd0, 6'd33, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    wait_idle();

    // Full-length command with address wrap on dst.
    for (int i = 0; i < 32; i++) mem[i] = 64'(i * 7 + 3);
    issue(3'd2, 3'd3, 6'd32, 5'd5, 5'd9, 5'd1, 5'd30, a1);
    wait_idle();

    // Reset in cycle 4 of a len-8 command.
    issue(3'd1, 3'd2, 6'd8, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    while (cyc < a1 + 3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_ren", rf_ren, 0);
    check_eq("mid_rst_alu_en", alu_enable, 0);
    check_eq("mid_rst_we", rf_we, 0);
    check_eq("mid_rst_wdata", rf_wdata, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    q_rd.delete(); q_alu.delete(); q_wr.delete(); q_done.delete(); q_err.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("post_rst_ready", cmd_ready, 1);

    // Back-to-back: second command held valid during the first.
    issue(3'd0, 3'd3, 6'd5, 5'd0, 5'd4, 5'd16, 5'd8, a1);
    issue(3'd2, 3'd3, 6'd2, 5'd2, 5'd6, 5'd18, 5'd10, a2);
    check_eq("b2b_accept_cycle", a2, a1 + 5 + 3);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
- Upstream issue/writeback sequencer for the 64-bit vector ALU in vector_processor_v1.
- Accepts one vector command per valid/ready handshake. Streams element operands from the vector register file (RF) read ports into the ALU, one element per cycle. Writes the registered ALU result back to the RF.
- Fully pipelined: read, then ALU, then writeback; throughput is 1 element per cycle.

Parameters:
- VLEN_MAX, 32, maximum elements per command.
- ADDR_W, 5, RF element address width. Addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 add, 1 mul, 2 sub, 3 mac
- cmd_width  in  3  0=8b, 1=16b, 2=32b, 3=64b
- cmd_len  in  6  element count, 0..VLEN_MAX
- cmd_src_a / cmd_src_b / cmd_src_c / cmd_dst  in  ADDR_W each  base element addresses
- rf_ren  out  1  RF read enable
- rf_raddr_a / rf_raddr_b / rf_raddr_c  out  ADDR_W each  read addresses
- rf_rdata_a / rf_rdata_b / rf_rdata_c  in  64 each  read data, valid 1 cycle after rf_ren
- alu_a / alu_b / alu_c  out  64 each  ALU operands
- alu_operation  out  3  ALU opcode
- alu_num_bits  out  3  ALU width select
- alu_enable  out  1  ALU enable
- alu_out  in  64  registered ALU result, valid 1 cycle after alu_enable
- rf_we  out  1  RF write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  64  write data
- busy  out  1  not IDLE
- done  out  1  1-cycle pulse, command complete
- err  out  1  1-cycle pulse, command rejected

Behaviour:
- Reset (rstn low, async): state IDLE; all pipeline valids, counters and registered outputs are 0. Only cmd_ready is 1.
- Reset mid-command: the command is abandoned. No further rf_ren or rf_we, and no done.
- States and transitions:
  - IDLE -> RUN on accept (cmd_valid && cmd_ready) of a legal command with cmd_len != 0.
  - RUN -> DRAIN after the read of the last element.
  - DRAIN -> IDLE after the last rf_we.
- cmd_ready = 1 only in IDLE. busy = (state != IDLE).
- On accept, latch op, width, len, and the four bases. alu_operation and alu_num_bits equal the latched values for the whole command and are 0 in IDLE.
- Illegal command (cmd_op > 3, cmd_width > 3, or cmd_len > VLEN_MAX):
  - Accepted; err = 1 in the next cycle.
  - No RF or ALU activity, no done; stays in IDLE.
- cmd_len == 0: accepted; done = 1 in the next cycle; no RF or ALU activity.
- Timing, with the accept edge as E0, element i in 0..N-1, and cycles numbered after E0:
  - Cycle 1+i: rf_ren = 1; rf_raddr_x = (src_x + i) mod 2^ADDR_W (registered).
  - Cycle 2+i: alu_enable = 1. alu_a/b/c = rf_rdata_a/b/c (combinational pass-through). Operands are 0 when alu_enable = 0.
  - Cycle 3+i: rf_we = 1; rf_waddr = (dst + i) mod 2^ADDR_W; rf_wdata = alu_out (combinational).
  - Cycle N+3: done = 1, state IDLE, cmd_ready = 1.
  - A new command is accepted at the end of cycle N+3 at the earliest.
- Total latency: N+3 cycles from accept to done. rf_ren, alu_enable and rf_we each stay high for N contiguous cycles.
- Address wrap: e.g. src 30, len 4 reads 30, 31, 0, 1. The same applies to dst.
- No hazard detection and no forwarding. Overlap between dst and any src is software's responsibility. The RF's own read-during-write rule applies.
- No result sign/zero extension is done here: rf_wdata = alu_out verbatim. Width masking is the ALU's job.
- cmd_* inputs are ignored while busy.

Test Plan:
- Reset then idle: rstn low, then high → cmd_ready = 1; busy, done, err, rf_ren, alu_enable, rf_we all 0.
- 8-bit add, len 4: src_a = 0, src_b = 4, dst = 8, RF a = {1,2,3,255}, b = {1,1,1,1}.
  - rf_ren in cycles 1–4, alu_enable in 2–5.
  - rf_we in 3–6 writes addresses 8..11 with {2,3,4,256}.
  - done in cycle 7.
- Wrap with 16-bit mac, len 3: src_a = 31, c = 5 everywhere, a*b = 6 → raddr_a sequence 31, 0, 1; writes 11 three times.
- Illegal command: cmd_op = 5 → err pulse in cycle 1; no rf_ren, no done; cmd_ready stays 1.
- Zero length: cmd_len = 0 → done in cycle 1; no RF traffic. cmd_len = 33 → err.
- Reset mid-command: len 8, rstn low in cycle 4 → all outputs 0 immediately; no rf_we after release; cmd_ready = 1.
- Back-to-back: second command held valid during the first → accepted in cycle N+3 of the first; its rf_ren starts the next cycle.
